// File: rtl/mont_redc128_serial_if.sv
// Handshake bundle for the serial Montgomery reduction stage.
// master: upstream/downstream side (drives operands and out_ready).
// slave : the reduction block (drives in_ready, out_valid, r_out, err).
interface mont_redc128_serial_if #(
  parameter int unsigned WIDTH = 128
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] t_in;
  logic [WIDTH-1:0]   n_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   r_out;
  logic               err;

  modport master (
    output in_valid, t_in, n_in, out_ready,
    input  in_ready, out_valid, r_out, err
  );

  modport slave (
    input  in_valid, t_in, n_in, out_ready,
    output in_ready, out_valid, r_out, err
  );
endinterface

// File: rtl/mont_redc128_serial.sv
// Bit-serial Montgomery reduction: r = T * 2^-WIDTH mod N, fully reduced.
// One conditional add of N plus a right shift per RED cycle, then one
// conditional-subtract FIX cycle. One operation in flight at a time.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus.slave in_valid/in_ready/t_in/n_in on the input side,
//             out_valid/out_ready/r_out/err on the output side
// Optional: define MONT_REDC_CHECK_EN to flag illegal operands (N even or
// T >= N*R) at accept; such operations skip to DONE with r_out=0, err=1.
module mont_redc128_serial #(
  parameter int unsigned WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  mont_redc128_serial_if.slave  bus
);
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RED, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ov_q, ov_d;
  logic             ir_q, ir_d;
  logic [WIDTH:0]   acc_lo;
`ifdef MONT_REDC_CHECK_EN
  logic             err_q, err_d;
  logic             bad_q, bad_d;
  logic             illegal;
`endif

  assign acc_lo = acc_q[WIDTH:0];

`ifdef MONT_REDC_CHECK_EN
  // Legal operands: N odd (hence nonzero) and T < N*R, i.e. T's high half < N.
  assign illegal = ~bus.n_in[0] | (bus.t_in[2*WIDTH-1:WIDTH] >= bus.n_in);
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    ov_d    = ov_q;
`ifdef MONT_REDC_CHECK_EN
    err_d   = err_q;
    bad_d   = bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && ir_q) begin
          acc_d   = {1'b0, bus.t_in};
          n_d     = bus.n_in;
          cnt_d   = '0;
          state_d = RED;
`ifdef MONT_REDC_CHECK_EN
          // Illegal operands bypass the loop; FIX then reports the error.
          bad_d = illegal;
          if (illegal) state_d = FIX;
`endif
        end
      end
      RED: begin
        if (acc_q[0]) acc_d = (acc_q + AW'(n_q)) >> 1;
        else          acc_d = acc_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // acc < 2N here, so one conditional subtract lands in [0, N).
        if (acc_lo >= {1'b0, n_q}) r_d = WIDTH'(acc_lo - {1'b0, n_q});
        else                       r_d = acc_lo[WIDTH-1:0];
`ifdef MONT_REDC_CHECK_EN
        if (bad_q) begin
          r_d   = '0;
          err_d = 1'b1;
        end
`endif
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
`ifdef MONT_REDC_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ir_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
`ifdef MONT_REDC_CHECK_EN
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
`ifdef MONT_REDC_CHECK_EN
      err_q   <= err_d;
      bad_q   <= bad_d;
`endif
    end
  end

  assign bus.in_ready  = ir_q;
  assign bus.out_valid = ov_q;
  assign bus.r_out     = r_q;
`ifdef MONT_REDC_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mont_redc128_serial.sv
// Randomized self-checking bench for mont_redc128_serial against a
// modular-halving reference model of T * 2^-128 mod N.
module tb_mont_redc128_serial;
  localparam int unsigned W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  mont_redc128_serial_if #(.WIDTH(W)) bus ();

  mont_redc128_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reduce T mod N, then divide by 2 modulo N, W times.
  function automatic logic [W-1:0] model(input logic [2*W-1:0] t, input logic [W-1:0] n);
    logic [2*W-1:0] tm;
    logic [W:0]     x;
    tm = t % {{W{1'b0}}, n};
    x  = (W+1)'(tm);
    for (int i = 0; i < W; i++) begin
      if (x[0]) x = (x + {1'b0, n}) >> 1;
      else      x = x >> 1;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_op(input logic [2*W-1:0] t, input logic [W-1:0] n);
    @(negedge clk);
    check("ready_before_accept", 256'(bus.in_ready), 256'(1));
    bus.in_valid = 1'b1;
    bus.t_in     = t;
    bus.n_in     = n;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Edges from the accepting edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (lat < 400) begin
      @(posedge clk);
      #1 lat++;
      if (bus.in_ready) saw_ready = 1'b1;
      if (bus.out_valid) break;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("valid_drop", 256'(bus.out_valid), 256'(0));
    check("ready_back", 256'(bus.in_ready), 256'(1));
  endtask

  task automatic run_op(input string tag, input logic [2*W-1:0] t, input logic [W-1:0] n,
                        input logic [W-1:0] exp);
    int lat;
    bit saw;
    start_op(t, n);
    wait_result(lat, saw);
    check({tag, "_latency"}, 256'(lat), 256'(W + 1));
    check({tag, "_ready_low"}, 256'(saw), 256'(0));
    check({tag, "_r"}, 256'(bus.r_out), 256'(exp));
    check({tag, "_err"}, 256'(bus.err), 256'(0));
    release_result();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] t;
    logic [W-1:0]   n, r_hold;
    int  lat;
    bit  saw, stable;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.t_in      = '0;
    bus.n_in      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_r_out", 256'(bus.r_out), 256'(0));
    check("rst_err", 256'(bus.err), 256'(0));

    // Directed values with hand-derived results
    run_op("t5n7", 256'(5), 128'(7), 128'(3));
    run_op("t1n3", 256'(1), 128'(3), 128'(1));
    run_op("t0n7", 256'(0), 128'(7), 128'(0));
    run_op("t6Rn7", 256'(6) << W, 128'(7), 128'(6));
    run_op("tmaxn7", (256'(7) << W) - 256'(1), 128'(7), 128'(5));
    run_op("t7n7", 256'(7), 128'(7), 128'(0));

    // Random odd N, T < N*R
    for (int i = 0; i < 8; i++) begin
      n = rand128() | 128'(1);
      if (i[0]) n[W-1] = 1'b1;
      t = {rand128() % n, rand128()};
      run_op("rand", t, n, model(t, n));
    end

    // Backpressure: result held, in_valid ignored while DONE
    n = rand128() | 128'(1);
    t = {rand128() % n, rand128()};
    start_op(t, n);
    wait_result(lat, saw);
    check("bp_latency", 256'(lat), 256'(W + 1));
    r_hold = bus.r_out;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.t_in     = {rand128(), rand128()};
      bus.n_in     = rand128();
      @(posedge clk);
      #1 if (bus.out_valid !== 1'b1 || bus.r_out !== r_hold || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("bp_stable", 256'(stable), 256'(1));
    check("bp_r", 256'(r_hold), 256'(model(t, n)));
    release_result();
    run_op("after_bp", 256'(5), 128'(7), 128'(3));

    // Reset mid-RED drops the operation
    start_op({rand128() % 128'(11), rand128()}, 128'(11));
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", 256'(bus.in_ready), 256'(1));
    check("midrst_out_valid", 256'(bus.out_valid), 256'(0));
    check("midrst_r_out", 256'(bus.r_out), 256'(0));
    run_op("after_rst", 256'(5), 128'(7), 128'(3));

`ifdef MONT_REDC_CHECK_EN
    start_op(256'(5), 128'(8));
    wait_result(lat, saw);
    check("even_latency", 256'(lat), 256'(1));
    check("even_err", 256'(bus.err), 256'(1));
    check("even_r", 256'(bus.r_out), 256'(0));
    release_result();
    check("even_err_clear", 256'(bus.err), 256'(0));
    start_op(256'(7) << W, 128'(7));
    wait_result(lat, saw);
    check("bigt_latency", 256'(lat), 256'(1));
    check("bigt_err", 256'(bus.err), 256'(1));
    release_result();
`else
    // Illegal operand still runs the full loop and returns to IDLE
    start_op(256'(5), 128'(8));
    wait_result(lat, saw);
    check("illegal_latency", 256'(lat), 256'(W + 1));
    check("illegal_err", 256'(bus.err), 256'(0));
    release_result();
`endif
    run_op("final", 256'(5), 128'(7), 128'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
